// File: rtl/imul_domain_req_arb.sv
// Two-domain request arbiter in front of the variable-latency multiplier.
// One transaction in flight; the result is routed back only to the issuing port.
//
// state | meaning
// IDLE  | waiting for a request, round-robin tie-break via prio_reg
// ISSUE | presenting msg_reg to the multiplier
// WAIT  | waiting for the multiplier result
// RESP  | presenting res_reg to the issuing port only
module imul_domain_req_arb #(
  parameter int p_msg_nbits = 67
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_val,
  output logic                   req0_rdy,
  input  logic [p_msg_nbits-1:0] req0_msg,
  input  logic                   req1_val,
  output logic                   req1_rdy,
  input  logic [p_msg_nbits-1:0] req1_msg,
  output logic                   resp0_val,
  input  logic                   resp0_rdy,
  output logic [31:0]            resp0_msg,
  output logic                   resp1_val,
  input  logic                   resp1_rdy,
  output logic [31:0]            resp1_msg,
  output logic                   mul_domain,
  output logic                   mul_in_val,
  input  logic                   mul_in_rdy,
  output logic [p_msg_nbits-1:0] mul_in_msg,
  input  logic                   mul_out_val,
  output logic                   mul_out_rdy,
  input  logic [31:0]            mul_out_msg
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   prio_reg;
  logic                   dom_reg;
  logic [p_msg_nbits-1:0] msg_reg;
  logic [31:0]            res_reg;
  logic                   acc0;
  logic                   acc1;
  logic                   resp_go;

  always_comb begin
    state_next  = state;
    req0_rdy    = 1'b0;
    req1_rdy    = 1'b0;
    mul_in_val  = 1'b0;
    mul_out_rdy = 1'b0;
    resp0_val   = 1'b0;
    resp1_val   = 1'b0;
    acc0        = 1'b0;
    acc1        = 1'b0;
    resp_go     = 1'b0;
    case (state)
      IDLE: begin
        req0_rdy = !prio_reg || !req1_val;
        req1_rdy = prio_reg || !req0_val;
        acc0     = req0_val && req0_rdy;
        acc1     = req1_val && req1_rdy && !acc0;
        if (acc0 || acc1) state_next = ISSUE;
      end
      ISSUE: begin
        mul_in_val = 1'b1;
        if (mul_in_rdy) state_next = WAIT;
      end
      WAIT: begin
        mul_out_rdy = 1'b1;
        if (mul_out_val) state_next = RESP;
      end
      RESP: begin
        resp0_val = !dom_reg;
        resp1_val = dom_reg;
        resp_go   = dom_reg ? resp1_rdy : resp0_rdy;
        if (resp_go) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The unselected response port is forced to zero so a high-domain result never leaks.
  assign resp0_msg  = (state == RESP && !dom_reg) ? res_reg : 32'd0;
  assign resp1_msg  = (state == RESP && dom_reg)  ? res_reg : 32'd0;
  assign mul_in_msg = msg_reg;
  assign mul_domain = dom_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      prio_reg <= 1'b0;
      dom_reg  <= 1'b0;
      msg_reg  <= '0;
      res_reg  <= 32'd0;
    end else begin
      state <= state_next;
      if (acc0 || acc1) begin
        msg_reg <= acc1 ? req1_msg : req0_msg;
        dom_reg <= acc1;
      end
      if (state == WAIT && mul_out_val) res_reg <= mul_out_msg;
      if (resp_go) prio_reg <= !dom_reg;
    end
  end

endmodule
